// File: rtl/gpr_scoreboard_file.sv
// General-purpose register file with per-register pending-write counters (scoreboard).
// Define GRF_BYPASS_EN to forward a same-cycle writeback onto the read ports.
module gpr_scoreboard_file #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5,
  parameter int unsigned PW = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [AW-1:0] rd_a1,
  input  logic [AW-1:0] rd_a2,
  output logic [DW-1:0] rd_d1,
  output logic [DW-1:0] rd_d2,
  output logic          rd_busy1,
  output logic          rd_busy2,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_a,
  output logic          iss_ready,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_a,
  input  logic [DW-1:0] wb_d,
  output logic          wb_err
);

  localparam int unsigned NREG = 2 ** AW;
  localparam logic [PW-1:0] PMAX = {PW{1'b1}};

  logic [DW-1:0] mem_q [NREG];
  logic [PW-1:0] cnt_q [NREG];
  logic [PW-1:0] cnt_d [NREG];
  logic          err_q, err_d;
  logic          iss_acc, wb_act, same_reg;

  // A same-cycle writeback does not free a slot for the issue check.
  assign iss_ready = (iss_a == '0) || (cnt_q[iss_a] != PMAX);
  assign iss_acc   = iss_valid && iss_ready && (iss_a != '0);
  assign wb_act    = wb_en && (wb_a != '0);
  assign same_reg  = iss_acc && wb_act && (iss_a == wb_a);
  assign wb_err    = err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (!same_reg) begin
      if (iss_acc) begin
        cnt_d[iss_a] = cnt_q[iss_a] + 1'b1;
      end
      if (wb_act) begin
        if (cnt_q[wb_a] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[wb_a] = cnt_q[wb_a] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (wb_act) begin
        mem_q[wb_a] <= wb_d;
      end
    end
  end

  always_comb begin
    rd_d1    = (rd_a1 == '0) ? '0 : mem_q[rd_a1];
    rd_busy1 = (rd_a1 != '0) && (cnt_q[rd_a1] != '0);
    rd_d2    = (rd_a2 == '0) ? '0 : mem_q[rd_a2];
    rd_busy2 = (rd_a2 != '0) && (cnt_q[rd_a2] != '0);
`ifdef GRF_BYPASS_EN
    // Last outstanding write resolving this cycle: the value is already here.
    if (wb_act && (wb_a == rd_a1)) begin
      rd_d1 = wb_d;
      if (cnt_q[rd_a1] == PW'(1)) rd_busy1 = 1'b0;
    end
    if (wb_act && (wb_a == rd_a2)) begin
      rd_d2 = wb_d;
      if (cnt_q[rd_a2] == PW'(1)) rd_busy2 = 1'b0;
    end
`endif
  end

endmodule

// File: doc/gpr_scoreboard_file.md
GPR_SCOREBOARD_FILE -- requirements
Module: gpr_scoreboard_file

Interface
REQ-001 Parameter DW, default 32: data width of each register, in bits.
REQ-002 Parameter AW, default 5: register address width; the file holds NREG = 2^AW registers.
REQ-003 Parameter PW, default 2: width of each per-register pending-write counter; PMAX = 2^PW-1.
REQ-004 Port CLK  in  1: single clock; all state updates on rising edge.
REQ-005 Port RESET  in  1: asynchronous, active-high reset.
REQ-006 Ports rd_a1, rd_a2  in  AW: read addresses.
REQ-007 Ports rd_d1, rd_d2  out  DW: read data.
REQ-008 Ports rd_busy1, rd_busy2  out  1: source register has unresolved pending write.
REQ-009 Port iss_valid  in  1: issue request claiming destination iss_a.
REQ-010 Port iss_a  in  AW: issued destination register.
REQ-011 Port iss_ready  out  1: issue can be accepted this cycle.
REQ-012 Port wb_en  in  1: writeback strobe.
REQ-013 Port wb_a  in  AW: writeback register address.
REQ-014 Port wb_d  in  DW: writeback data.
REQ-015 Port wb_err  out  1: sticky flag, writeback without matching issue.

Function
REQ-016 Register 0 SHALL always read 0, never be written, never report busy; its counter SHALL stay 0.
REQ-017 Reads SHALL be combinational (zero latency) from the array, subject to REQ-024.
REQ-018 iss_ready SHALL be 1 when iss_a==0 or cnt[iss_a]!=PMAX; a same-cycle writeback to iss_a does not free a slot.
REQ-019 An issue is accepted when iss_valid && iss_ready; for iss_a!=0 the counter increments at the next edge.
REQ-020 A writeback with wb_en && wb_a!=0 SHALL write wb_d into the array at the next edge and decrement cnt[wb_a].
REQ-021 Accepted issue and writeback to the same register in one cycle SHALL leave the counter unchanged; the array is still written.
REQ-022 Writeback when cnt[wb_a]==0 (no same-cycle issue) SHALL still write data, keep counter at 0 and set wb_err at the next edge; wb_err clears only on reset.
REQ-023 rd_busyN SHALL be 1 when rd_aN!=0 and cnt[rd_aN]!=0, except as relaxed by REQ-024.
REQ-024 Bypass (see Configuration): when wb_en, wb_a==rd_aN, wb_a!=0, rd_dN SHALL equal wb_d, and rd_busyN SHALL be 0 if cnt[rd_aN]==1.
REQ-025 Counters SHALL never wrap: increment blocked at PMAX by iss_ready, decrement clamped at 0.
REQ-026 iss_valid with iss_ready==0 SHALL be ignored entirely; the requester holds it.

Reset
REQ-027 While RESET is high, all registers, all counters and wb_err SHALL be 0 immediately, independent of CLK.
REQ-028 Reset mid-operation SHALL discard all in-flight issues; after release all rd_busy are 0 and iss_ready is 1.
REQ-029 Issues or writebacks presented in the cycle RESET deasserts SHALL take effect at the first rising edge with RESET low.

Configuration
REQ-030 Macro GRF_BYPASS_EN defined: REQ-024 forwarding active.
REQ-031 Macro GRF_BYPASS_EN undefined: rd_dN reads the array only, rd_busyN follows REQ-023 unrelaxed, so a same-cycle writeback value is visible one cycle later.

Verification
REQ-032 Reset, read all addresses -> all rd_d 0, rd_busy 0, iss_ready 1, wb_err 0.
REQ-033 Issue $5; next cycle rd_a1=5 -> rd_busy1=1; wb $5=0x12345678 with rd_a1=5 -> bypass on: rd_d1=0x12345678, rd_busy1=0; off: rd_busy1=1, next cycle rd_d1=0x12345678, rd_busy1=0.
REQ-034 Issue $7 three times (PW=2) -> iss_ready=0 for iss_a=7, fourth held issue not counted; three writebacks -> busy clears after third.
REQ-035 Same-cycle issue and wb to $9 with cnt=1 -> cnt stays 1, rd_busy stays 1, array holds wb data.
REQ-036 wb $3 with no issue -> $3 written, wb_err=1 next cycle and stays 1; write to $0=0xFFFFFFFF -> $0 reads 0, wb_err unchanged.
REQ-037 Assert RESET asynchronously between edges with $4 pending -> rd_busy 0 and all data 0 before the next edge.
